// File: rtl/dpram_pkg.sv
// Constants shared between the DPRAM and its read-side stream engine.
package dpram_pkg;

  localparam int DPRAM_DATA_WIDTH = 8;
  localparam int DPRAM_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO whose head register drives the output stream directly.
// Latency: push visible on o_m_valid next cycle; pop frees a slot the same edge.
module stream_fifo2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_occ;
  logic                  r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (i_push) begin
            r_head  <= i_push_data;
            r_occ   <= 2'd1;
            r_valid <= 1'b1;
          end
        end
        2'd1: begin
          if (i_push && i_pop) begin
            r_head <= i_push_data;
          end else if (i_push) begin
            r_tail <= i_push_data;
            r_occ  <= 2'd2;
          end else if (i_pop) begin
            r_occ   <= 2'd0;
            r_valid <= 1'b0;
          end
        end
        default: begin
          // Full: the tail shifts into the head on every pop.
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) begin
              r_tail <= i_push_data;
            end else begin
              r_occ <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign o_occ     = r_occ;
  assign o_m_data  = r_head;
  assign o_m_valid = r_valid;

endmodule

// File: rtl/dpram_stream_reader.sv
// Streams a block of consecutive DPRAM words out over valid/ready.
// First beat three cycles after start; reads are throttled so the 2-entry buffer never overflows.
module dpram_stream_reader
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_add,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  rd_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_rd_add;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_pending;
  logic                  r_busy;
  logic                  r_done;

  logic [1:0]            w_occ;
  logic [2:0]            w_fill;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_drained;

  assign w_pop  = m_valid & m_ready;
  assign w_fill = {1'b0, w_occ} + {2'b00, r_pending};

  // A read may go out only if its data is guaranteed a buffer slot when it lands.
  assign w_issue = (r_state == ST_FETCH) && (r_remaining != '0) &&
                   (w_fill < (3'd2 + {2'b00, w_pop}));

  assign w_drained = !r_pending &&
                     ((w_occ == 2'd0) || ((w_occ == 2'd1) && w_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rd_add    <= '0;
      r_remaining <= '0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_pending <= w_issue;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (length != '0) begin
              r_state     <= ST_FETCH;
              r_rd_add    <= base_addr;
              r_remaining <= length;
              r_busy      <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (w_issue) begin
            r_rd_add    <= r_rd_add + ADDR_WIDTH'(1);
            r_remaining <= r_remaining - (ADDR_WIDTH + 1)'(1);
            if (r_remaining == (ADDR_WIDTH + 1)'(1)) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  stream_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_pending),
    .i_push_data(ram_q),
    .i_pop      (w_pop),
    .o_occ      (w_occ),
    .o_m_data   (m_data),
    .o_m_valid  (m_valid)
  );

  assign busy   = r_busy;
  assign done   = r_done;
  assign rd_add = r_rd_add;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench: a 10-bit and a 4-bit address instance, each beside a DPRAM whose word i holds i.
module tb_dpram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_ready = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [9:0]  base = '0;
  logic [10:0] len = '0;

  logic       busy_a, done_a, m_valid_a;
  logic [9:0] rd_add_a;
  logic [7:0] ram_q_a, m_data_a;
  logic       busy_b, done_b, m_valid_b;
  logic [3:0] rd_add_b;
  logic [7:0] ram_q_b, m_data_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
  always @(posedge clk) ram_q_a <= mem[rd_add_a];
  always @(posedge clk) ram_q_b <= mem[{6'd0, rd_add_b}];

  dpram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base), .length(len),
    .busy(busy_a), .done(done_a), .rd_add(rd_add_a), .ram_q(ram_q_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready));

  dpram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base[3:0]), .length(len[4:0]),
    .busy(busy_b), .done(done_b), .rd_add(rd_add_b), .ram_q(ram_q_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready));

  // Stream observation, sampled mid-cycle.
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [3:0] addr_b[$];
  int   first_v[2], busy_first[2], busy_cnt[2], done_cnt[2], done_cyc[2], stab_err[2];
  int   max_occ;
  logic stall_p[2];
  logic [7:0] data_p[2];

  task automatic note(input int s, input logic v, input logic b, input logic d, input logic [7:0] dat);
    if (v && first_v[s] < 0) first_v[s] = cyc;
    if (b) begin
      busy_cnt[s]++;
      if (busy_first[s] < 0) busy_first[s] = cyc;
    end
    if (d) begin
      done_cnt[s]++;
      done_cyc[s] = cyc;
    end
    if (stall_p[s] && (!v || dat !== data_p[s])) stab_err[s]++;
    stall_p[s] = v && !m_ready;
    data_p[s]  = dat;
  endtask

  always @(negedge clk) begin
    if (m_valid_a && m_ready) q_a.push_back(m_data_a);
    if (m_valid_b && m_ready) q_b.push_back(m_data_b);
    if (busy_b && (addr_b.size() == 0 || addr_b[$] != rd_add_b)) addr_b.push_back(rd_add_b);
    if (int'(u_b.w_occ) > max_occ) max_occ = int'(u_b.w_occ);
    note(0, m_valid_a, busy_a, done_a, m_data_a);
    note(1, m_valid_b, busy_b, done_b, m_data_b);
  end

  task automatic clear_mon();
    q_a.delete();
    q_b.delete();
    addr_b.delete();
    max_occ = 0;
    for (int s = 0; s < 2; s++) begin
      first_v[s] = -1; busy_first[s] = -1; busy_cnt[s] = 0;
      done_cnt[s] = 0; done_cyc[s] = -1; stab_err[s] = 0;
      stall_p[s] = 1'b0; data_p[s] = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_beats(input string tag, input bit sel, input int b, input int n, input int m);
    int sz = sel ? q_b.size() : q_a.size();
    chk({tag, "_count"}, sz, n);
    for (int i = 0; i < n && i < sz; i++)
      chk({tag, "_data"}, sel ? q_b[i] : q_a[i], (b + i) % m);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic go(input bit sel, input int b, input int l, output int c0);
    @(posedge clk); #1;
    base = b[9:0];
    len  = l[10:0];
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // mode 0: ready high; 1: toggling 1,0,1,0 from first beat; 2: low for offsets lo..hi.
  task automatic run(input bit sel, input int c0, input int maxc, input int mode, input int lo, input int hi);
    int n = 0;
    while (done_cnt[sel ? 1 : 0] == 0 && n < maxc) begin
      case (mode)
        1:       m_ready = ((cyc - c0) % 2) == 1;
        2:       m_ready = !((cyc - c0) >= lo && (cyc - c0) <= hi);
        default: m_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      n++;
    end
    m_ready = 1'b1;
  endtask

  initial begin
    int c0;
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    clear_mon();
    tick(3);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_data", m_data_a, 0);
    chk("rst_rd_add", rd_add_a, 0);
    chk("rst_b_valid", m_valid_b, 0);
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick(2);

    // 1: base 0, length 4, ready high
    clear_mon();
    go(0, 0, 4, c0);
    run(0, c0, 40, 0, 0, 0);
    chk("t1_first_valid", first_v[0], c0 + 3);
    chk("t1_busy_first", busy_first[0], c0 + 1);
    chk("t1_busy_cycles", busy_cnt[0], 6);
    chk("t1_done_cnt", done_cnt[0], 1);
    chk("t1_done_cyc", done_cyc[0], c0 + 7);
    chk_beats("t1", 0, 0, 4, 1024);

    // 2: base 16, length 8, ready toggling
    clear_mon();
    go(0, 16, 8, c0);
    run(0, c0, 80, 1, 0, 0);
    chk("t2_done_cnt", done_cnt[0], 1);
    chk("t2_stall_stable", stab_err[0], 0);
    chk_beats("t2", 0, 16, 8, 1024);

    // 3: 4-bit address wrap
    clear_mon();
    go(1, 14, 4, c0);
    run(1, c0, 40, 0, 0, 0);
    chk("t3_done_cyc", done_cyc[1], c0 + 7);
    chk("t3_addr_n_ge4", addr_b.size() >= 4, 1);
    for (int i = 0; i < 4 && i < addr_b.size(); i++)
      chk("t3_rd_add", addr_b[i], (14 + i) % 16);
    chk_beats("t3", 1, 14, 4, 16);

    // 4: zero length
    clear_mon();
    go(0, 7, 0, c0);
    tick(4);
    chk("t4_done_cnt", done_cnt[0], 1);
    chk("t4_done_cyc", done_cyc[0], c0 + 1);
    chk("t4_busy_cycles", busy_cnt[0], 0);
    chk("t4_no_valid", first_v[0], -1);

    // 5: full-depth wrap with a 3-cycle stall
    clear_mon();
    go(1, 5, 16, c0);
    run(1, c0, 100, 2, 6, 8);
    chk("t5_done_cnt", done_cnt[1], 1);
    chk("t5_done_cyc", done_cyc[1], c0 + 22);
    chk("t5_stall_stable", stab_err[1], 0);
    chk("t5_occ_le2", max_occ <= 2, 1);
    chk_beats("t5", 1, 5, 16, 16);

    // 6a: start while busy is ignored
    clear_mon();
    go(0, 100, 3, c0);
    @(posedge clk); #1;
    base = 10'd200; len = 11'd5; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    run(0, c0, 40, 0, 0, 0);
    tick(6);
    chk("t6a_done_cnt", done_cnt[0], 1);
    chk("t6a_done_cyc", done_cyc[0], c0 + 6);
    chk_beats("t6a", 0, 100, 3, 1024);

    // 6b: reset after two beats
    clear_mon();
    go(0, 200, 10, c0);
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("t6b_rst_valid", m_valid_a, 0);
    chk("t6b_rst_busy", busy_a, 0);
    chk("t6b_rst_data", m_data_a, 0);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    chk("t6b_no_done", done_cnt[0], 0);
    chk_beats("t6b", 0, 200, 2, 1024);

    // 6c: clean command after the abort
    clear_mon();
    go(0, 3, 2, c0);
    run(0, c0, 40, 0, 0, 0);
    chk("t6c_done_cnt", done_cnt[0], 1);
    chk_beats("t6c", 0, 3, 2, 1024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
